// File: rtl/lct_dly_scan_ctrl.sv
// LCT delay-line scan sequencer.
// Sweeps the 3-bit delay select through all eight settings. At each setting it
// counts DLY_LCT/REF coincidences and then holds the delay with the most hits.
// Outside a scan, the manual delay passes through unless a held result is valid.
module lct_dly_scan_ctrl #(
    parameter int SETTLE = 8,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 11
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [2:0]       MAN_DLY,
    input  logic             CLR_RES,
    input  logic             DLY_LCT,
    input  logic             REF,
    output logic [2:0]       DELAY,
    output logic             BUSY,
    output logic             DONE,
    output logic             RES_VALID,
    output logic             NOHIT,
    output logic [2:0]       BEST_DLY,
    output logic [CNT_W-1:0] BEST_CNT
);

    localparam int TMAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       d_q, d_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic [2:0]       best_idx_q, best_idx_d;
    logic [2:0]       best_dly_q, best_dly_d;
    logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
    logic             res_valid_q, res_valid_d;
    logic             nohit_q, nohit_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        tmr_d       = tmr_q;
        hit_d       = hit_q;
        max_d       = max_q;
        best_idx_d  = best_idx_q;
        best_dly_d  = best_dly_q;
        best_cnt_d  = best_cnt_q;
        res_valid_d = res_valid_q;
        nohit_d     = nohit_q;

        // Abort outranks every transition and leaves the held result untouched.
        if (ABORT && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (CLR_RES) begin
                        res_valid_d = 1'b0;
                        nohit_d     = 1'b0;
                    end
                    if (START && !ABORT) begin
                        state_d    = ST_SETTLE;
                        d_d        = '0;
                        tmr_d      = '0;
                        max_d      = '0;
                        best_idx_d = '0;
                    end
                end
                ST_SETTLE: begin
                    hit_d = '0;
                    if (tmr_q == TW'(SETTLE - 1)) begin
                        tmr_d   = '0;
                        state_d = ST_SAMPLE;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (DLY_LCT && REF && (hit_q != '1)) begin
                        hit_d = hit_q + CNT_W'(1);
                    end
                    if (tmr_q == TW'(WINDOW - 1)) begin
                        tmr_d   = '0;
                        state_d = ST_EVAL;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                ST_EVAL: begin
                    // Strict compare keeps the lowest delay on a tie.
                    if (hit_q > max_q) begin
                        max_d      = hit_q;
                        best_idx_d = d_q;
                    end
                    if (d_q == 3'd7) begin
                        state_d = ST_FIN;
                    end else begin
                        d_d     = d_q + 3'd1;
                        state_d = ST_SETTLE;
                    end
                end
                ST_FIN: begin
                    if (max_q != '0) begin
                        best_dly_d  = best_idx_q;
                        best_cnt_d  = max_q;
                        res_valid_d = 1'b1;
                        nohit_d     = 1'b0;
                    end else begin
                        best_dly_d  = '0;
                        best_cnt_d  = '0;
                        res_valid_d = 1'b0;
                        nohit_d     = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE) || (state_d == ST_EVAL);
        done_d = (state_d == ST_FIN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            d_q         <= '0;
            tmr_q       <= '0;
            hit_q       <= '0;
            max_q       <= '0;
            best_idx_q  <= '0;
            best_dly_q  <= '0;
            best_cnt_q  <= '0;
            res_valid_q <= 1'b0;
            nohit_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            tmr_q       <= tmr_d;
            hit_q       <= hit_d;
            max_q       <= max_d;
            best_idx_q  <= best_idx_d;
            best_dly_q  <= best_dly_d;
            best_cnt_q  <= best_cnt_d;
            res_valid_q <= res_valid_d;
            nohit_q     <= nohit_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Delay select: scan index while scanning, else held result or manual value.
    always_comb begin
        if (state_q == ST_IDLE) begin
            DELAY = res_valid_q ? best_dly_q : MAN_DLY;
        end else begin
            DELAY = d_q;
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RES_VALID = res_valid_q;
    assign NOHIT     = nohit_q;
    assign BEST_DLY  = best_dly_q;
    assign BEST_CNT  = best_cnt_q;

endmodule

// File: tb/tb_lct_dly_scan_ctrl.sv
// Scoreboard bench for lct_dly_scan_ctrl with a behavioural 0-7 cycle delay line.
module tb_lct_dly_scan_ctrl;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [2:0]       man_dly = 3'd0;
    logic             clr_res = 1'b0;
    logic             dly_lct;
    logic             ref_s;
    logic [2:0]       delay;
    logic             busy, done, res_valid, nohit;
    logic [2:0]       best_dly;
    logic [CNT_W-1:0] best_cnt;

    lct_dly_scan_ctrl #(
        .SETTLE(8),
        .WINDOW(16),
        .CNT_W (CNT_W)
    ) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .START    (start),
        .ABORT    (abort),
        .MAN_DLY  (man_dly),
        .CLR_RES  (clr_res),
        .DLY_LCT  (dly_lct),
        .REF      (ref_s),
        .DELAY    (delay),
        .BUSY     (busy),
        .DONE     (done),
        .RES_VALID(res_valid),
        .NOHIT    (nohit),
        .BEST_DLY (best_dly),
        .BEST_CNT (best_cnt)
    );

    always #5 clk = ~clk;

    // Edge counter: during the cycle ending at absolute edge N, ecnt == N.
    int         ecnt = 0;
    int         s0 = -1000;
    int         mode = 0;      // 0: DIN low, 1: pulse every 10 cycles, 2: DIN high
    logic       ref_kill = 1'b0;
    logic       din;
    logic [6:0] sr = '0;

    always_comb begin
        din = 1'b0;
        if (mode == 2) din = 1'b1;
        else if (mode == 1) din = (ecnt >= s0) && (((ecnt - s0) % 10) == 0);
    end

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        sr   <= {sr[5:0], din};
    end

    always_comb begin
        case (delay)
            3'd0:    dly_lct = din;
            3'd1:    dly_lct = sr[0];
            3'd2:    dly_lct = sr[1];
            3'd3:    dly_lct = sr[2];
            3'd4:    dly_lct = sr[3];
            3'd5:    dly_lct = sr[4];
            3'd6:    dly_lct = sr[5];
            default: dly_lct = sr[6];
        endcase
        ref_s = ref_kill ? 1'b0 : sr[2];
    end

    typedef struct {
        int               edge_n;
        logic [2:0]       bdly;
        logic [CNT_W-1:0] bcnt;
        logic             rv;
        logic             nh;
        logic [2:0]       dly;
    } exp_t;

    exp_t sb[$];
    exp_t pexp;
    logic pend = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops one expectation per DONE pulse, checks results the cycle after.
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            check("best_dly", int'(best_dly), int'(pexp.bdly));
            check("best_cnt", int'(best_cnt), int'(pexp.bcnt));
            check("res_valid", int'(res_valid), int'(pexp.rv));
            check("nohit", int'(nohit), int'(pexp.nh));
            check("delay_after_scan", int'(delay), int'(pexp.dly));
            check("done_one_cycle", int'(done), 0);
        end
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got DONE=1 expected no DONE (t=%0t)", $time);
            end else begin
                pexp = sb.pop_front();
                check("done_edge", ecnt - 1, pexp.edge_n);
                check("busy_at_done", int'(busy), 0);
                pend = 1'b1;
            end
        end
    end

    function automatic exp_t mk(input logic [2:0] bd, input int bc, input logic rv,
                                input logic nh, input logic [2:0] dl);
        exp_t e;
        e.edge_n = 0;
        e.bdly   = bd;
        e.bcnt   = CNT_W'(bc);
        e.rv     = rv;
        e.nh     = nh;
        e.dly    = dl;
        return e;
    endfunction

    // Issue START (optionally with CLR_RES); DONE expected 200 edges after the capturing edge.
    task automatic start_scan(input logic push, input exp_t e, input logic clr);
        @(negedge clk);
        start   = 1'b1;
        clr_res = clr;
        s0      = ecnt;
        if (push) begin
            e.edge_n = s0 + 200;
            sb.push_back(e);
        end
        @(negedge clk);
        start   = 1'b0;
        clr_res = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input int limit);
        int k;
        int n;
        k = done_cnt;
        n = 0;
        while ((done_cnt == k) && (n < limit)) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == k) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", limit);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rel(input int rel);
        int n;
        n = 0;
        while ((ecnt < s0 + rel) && (n < 1000)) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(negedge clk);
        // Reset state
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_nohit", int'(nohit), 0);
        check("rst_best_dly", int'(best_dly), 0);
        check("rst_best_cnt", int'(best_cnt), 0);
        check("rst_delay", int'(delay), 0);
        rst_n = 1'b1;
        man_dly = 3'd6;
        @(negedge clk);
        check("man_dly_passthru", int'(delay), 6);

        // Pulses every 10 cycles, REF = DIN delayed 3. Only d=3 hits; its sample
        // edges are 84..99 after START, REF high there only at edge 93 -> 1 hit.
        mode = 1;
        start_scan(1'b1, mk(3'd3, 1, 1'b1, 1'b0, 3'd3), 1'b0);
        wait_rel(30);
        check("delay_step_d1", int'(delay), 1);
        wait_done(400);

        // DIN and REF high: every setting counts 16, tie resolves to d=0.
        mode = 2;
        start_scan(1'b1, mk(3'd0, 16, 1'b1, 1'b0, 3'd0), 1'b0);
        wait_done(400);

        // REF low with MAN_DLY=5; START with CLR_RES clears held result at once.
        mode = 1;
        ref_kill = 1'b1;
        man_dly = 3'd5;
        start_scan(1'b1, mk(3'd0, 0, 1'b0, 1'b1, 3'd5), 1'b1);
        check("clr_with_start_rv", int'(res_valid), 0);
        wait_done(400);
        ref_kill = 1'b0;

        // Re-establish BEST_DLY=3, then abort during d=4 SAMPLE.
        start_scan(1'b1, mk(3'd3, 1, 1'b1, 1'b0, 3'd3), 1'b0);
        wait_done(400);
        start_scan(1'b0, mk(3'd0, 0, 1'b0, 1'b0, 3'd0), 1'b0);
        wait_rel(112);
        check("delay_d4_sample", int'(delay), 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_delay", int'(delay), 3);
        check("abort_res_valid", int'(res_valid), 1);
        check("abort_best_cnt", int'(best_cnt), 1);
        k = done_cnt;
        repeat (120) @(negedge clk);
        check("abort_no_done", done_cnt, k);

        // Reset during d=6.
        man_dly = 3'd2;
        start_scan(1'b0, mk(3'd0, 0, 1'b0, 1'b0, 3'd0), 1'b0);
        wait_rel(160);
        check("delay_d6", int'(delay), 6);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_res_valid", int'(res_valid), 0);
        check("midrst_nohit", int'(nohit), 0);
        check("midrst_best_dly", int'(best_dly), 0);
        check("midrst_best_cnt", int'(best_cnt), 0);
        check("midrst_delay", int'(delay), 2);
        rst_n = 1'b1;
        @(negedge clk);
        start_scan(1'b1, mk(3'd3, 1, 1'b1, 1'b0, 3'd3), 1'b0);
        wait_done(400);

        // START pulsed repeatedly while busy: one DONE only.
        k = done_cnt;
        start_scan(1'b1, mk(3'd3, 1, 1'b1, 1'b0, 3'd3), 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (20) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(400);
        repeat (30) @(negedge clk);
        check("one_done_per_scan", done_cnt - k, 1);
        check("idle_after_restarts", int'(busy), 0);

        // CLR_RES in IDLE reverts DELAY to MAN_DLY.
        man_dly = 3'd1;
        clr_res = 1'b1;
        @(negedge clk);
        clr_res = 1'b0;
        check("clr_res_valid", int'(res_valid), 0);
        check("clr_nohit", int'(nohit), 0);
        check("clr_delay", int'(delay), 1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lct_dly_scan_ctrl.md
Name: lct_dly_scan_ctrl

Overview:
Sequencer for the programmable TMB LCT delay line (0–7 clock delay, 3-bit DELAY select). It drives the delay line's DELAY input and sweeps all eight settings. At each setting it counts coincidences between the delayed LCT and a reference timing strobe. It then selects and holds the setting with the most hits. Sits between the DMB control/configuration registers and the LCT delay line; in normal running it passes the manually configured delay through.

Parameters:
SETTLE, 8, cycles held at each new delay before counting (must be >= 8 to flush the 7-stage shift register)
WINDOW, 1024, sample cycles counted per delay setting
CNT_W, 11, width of hit counters (must hold WINDOW; counters saturate)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  synchronous reset, active-low
START  in  1  start-scan pulse; sampled only in IDLE
ABORT  in  1  abort scan; returns to IDLE next cycle
MAN_DLY  in  3  manually configured delay, used when no scan result is valid
CLR_RES  in  1  invalidates held scan result (DELAY reverts to MAN_DLY)
DLY_LCT  in  1  delay-line output (delayed LCT) fed back
REF  in  1  reference strobe marking the correct LCT arrival cycle
DELAY  out  3  delay select to the delay line
BUSY  out  1  high from first cycle after accepted START until DONE
DONE  out  1  one-cycle pulse at scan completion
RES_VALID  out  1  held scan result in use
NOHIT  out  1  last completed scan found zero hits at all delays
BEST_DLY  out  3  selected delay from last completed scan
BEST_CNT  out  CNT_W  hit count at BEST_DLY

Behaviour:
- Reset (RST_N=0 at CLK edge): state IDLE; DELAY=MAN_DLY (combinational pass-through while RES_VALID=0); BUSY=0, DONE=0, RES_VALID=0, NOHIT=0, BEST_DLY=0, BEST_CNT=0; internal counters cleared. Reset mid-scan discards all partial results.
- States: IDLE, SETTLE, SAMPLE, EVAL, FIN.
- IDLE: DELAY = RES_VALID ? BEST_DLY : MAN_DLY. START=1 -> SETTLE, step index d=0, running max cleared, BUSY=1 from next cycle.
- SETTLE: DELAY=d; counts SETTLE cycles, then -> SAMPLE. The hit counter is cleared on entry.
- SAMPLE: DELAY=d; for WINDOW cycles, hit counter +1 on each cycle with DLY_LCT & REF, saturating at 2^CNT_W-1. Then -> EVAL.
- EVAL (1 cycle): if hit > running max, running max=hit and best index=d (strict >, so the lowest delay wins ties). If d=7 -> FIN, else d=d+1 -> SETTLE.
- FIN (1 cycle): DONE=1 and BUSY=0 in this cycle. If running max>0: BEST_DLY=best index, BEST_CNT=max, RES_VALID=1, NOHIT=0. Otherwise: BEST_DLY=0, BEST_CNT=0, RES_VALID=0, NOHIT=1. Then -> IDLE.
- Scan length from START to DONE: 8*(SETTLE+WINDOW+1)+1 cycles.
- START while not IDLE: ignored.
- ABORT (any non-IDLE state): -> IDLE next cycle; BUSY=0; no DONE. BEST_*, RES_VALID and NOHIT keep their pre-scan values. ABORT has priority over all state transitions; ABORT and START together in IDLE: START ignored.
- CLR_RES in IDLE: RES_VALID=0 and NOHIT=0 next cycle. During a scan it is ignored. START and CLR_RES together in IDLE: the scan starts and the clear also applies.
- MAN_DLY changes take effect on DELAY immediately in IDLE when RES_VALID=0; they have no effect during a scan.

Test Plan:
- SETTLE=8, WINDOW=16; DIN pulse every 10 cycles; REF = DIN delayed exactly 3 cycles; START -> DELAY steps 0..7; only d=3 yields hits; DONE at cycle 201; BEST_DLY=3, RES_VALID=1, DELAY=3 in IDLE.
- DIN and REF held high continuously -> every setting counts 16; the tie resolves to BEST_DLY=0 with BEST_CNT=16.
- REF held low, MAN_DLY=5 -> DONE with NOHIT=1, RES_VALID=0, DELAY=5 after scan.
- After a valid result BEST_DLY=3, START a new scan and assert ABORT during d=4 SAMPLE -> IDLE next cycle, no DONE pulse, DELAY=3, RES_VALID=1 unchanged.
- RST_N=0 during d=6 -> next cycle all outputs at reset values; DELAY follows MAN_DLY=2; a later START runs a full clean scan.
- START pulsed repeatedly while BUSY, then CLR_RES in IDLE -> exactly one DONE per scan; after CLR_RES, DELAY=MAN_DLY and RES_VALID=0.
